axis_latency_histogram: RTL and testbench

- Sink-side statistics endpoint attached to one mesh output port (axis_out_* of a router endpoint), alongside or in place of the per-endpoint checker.
- Extracts the injection timestamp carried in tdata, computes end-to-end latency against the shared ticks counter and accumulates a binned histogram plus running count, sum, min and max.
- A host or bench reads the bins through a synchronous read port after a load sweep and clears them between sweeps.

---
 rtl/axis_stats_pkg.sv | 36 +++
 rtl/axis_latency_histogram_hist_ram.sv | 31 +++
 rtl/axis_latency_histogram.sv | 152 +++++++++++++++
 tb/tb_axis_latency_histogram.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stats_pkg.sv
// Shared types and helpers for the AXI-Stream latency statistics endpoint.
`default_nettype none

package axis_stats_pkg;

  localparam int TS_MAX_WIDTH = 512;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int ts_width(input int tdata_width);
    return tdata_width / 2;
  endfunction

  // Timestamp lives in the low half of tdata; callers narrow the result to ts_width().
  function automatic logic [TS_MAX_WIDTH-1:0] ts_slice(input logic [2*TS_MAX_WIDTH-1:0] tdata,
                                                       input int tdata_width);
    logic [TS_MAX_WIDTH-1:0] ts;
    ts = '0;
    for (int i = 0; i < TS_MAX_WIDTH; i++) begin
      if (i < ts_width(tdata_width)) ts[i] = tdata[i];
    end
    return ts;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_latency_histogram_hist_ram.sv
// Histogram bin storage: one write port, one update read port, one host read port (read-before-write).
`default_nettype none

module hist_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              rclr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    if (rclr_b) rdata_b <= '0;
    else        rdata_b <= mem[raddr_b];
  end

endmodule

`default_nettype wire

// File: rtl/axis_latency_histogram.sv
// Sink-side latency statistics: binned histogram plus count, sum, min and max of end-to-end latency.
`default_nettype none

module axis_latency_histogram
  import axis_stats_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST       = 0,
  parameter int NUM_BINS    = 64,
  parameter int BIN_SHIFT   = 2,
  parameter int BIN_WIDTH   = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TDATA_WIDTH/2-1:0]      ticks,
  input  logic                          clear,
  output logic                          busy,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]        axis_in_tdata,
  input  logic                          axis_in_tlast,
  input  logic [TID_WIDTH-1:0]          axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]        axis_in_tdest,
  input  logic [$clog2(NUM_BINS)-1:0]   rd_addr,
  output logic [BIN_WIDTH-1:0]          rd_data,
  output logic [COUNT_WIDTH-1:0]        pkt_count,
  output logic [TDATA_WIDTH/2-1:0]      lat_sum,
  output logic [TDATA_WIDTH/2-1:0]      lat_min,
  output logic [TDATA_WIDTH/2-1:0]      lat_max,
  output logic                          error
);

  localparam int TS_W   = ts_width(TDATA_WIDTH);
  localparam int BIN_AW = $clog2(NUM_BINS);
  localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(NUM_BINS - 1);

  clr_state_e            state, state_next;
  logic [BIN_AW-1:0]     clr_addr;
  logic                  accept, take;
  logic [TS_W-1:0]       timestamp;
  logic                  s1_valid, s2_valid, s3_valid;
  logic [TS_W-1:0]       s1_lat, s2_lat;
  logic [BIN_AW-1:0]     s1_bin, s2_bin, s3_bin;
  logic [BIN_WIDTH-1:0]  s3_val, ram_rdata, rmw_base, rmw_val;
  logic                  ram_we;
  logic [BIN_AW-1:0]     ram_waddr;
  logic [BIN_WIDTH-1:0]  ram_wdata;
  logic                  unused_tid;

  assign unused_tid = ^axis_in_tid;

  function automatic logic [BIN_AW-1:0] bin_of(input logic [TS_W-1:0] lat);
    logic [TS_W-1:0] scaled;
    scaled = lat >> BIN_SHIFT;
    if (scaled > TS_W'(NUM_BINS - 1)) return LAST_BIN;
    return BIN_AW'(scaled);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE:  if (clear) state_next = ST_CLEAR;
      ST_CLEAR: begin
        busy = 1'b1;
        if (!clear && clr_addr == LAST_BIN) state_next = ST_IDLE;
      end
      default:  state_next = ST_CLEAR;
    endcase
  end

  // A clear during the sweep restarts it from bin 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clear)      clr_addr <= '0;
    else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  assign axis_in_tready = !busy;
  assign accept         = axis_in_tvalid && axis_in_tready;
  assign take           = accept && axis_in_tlast && !clear;
  assign timestamp      = TS_W'(ts_slice((2*TS_MAX_WIDTH)'(axis_in_tdata), TDATA_WIDTH));
  assign s1_bin         = bin_of(s1_lat);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= take;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
    s1_lat <= ticks - timestamp;
    s2_lat <= s1_lat;
    s2_bin <= s1_bin;
    s3_bin <= s2_bin;
    s3_val <= rmw_val;
  end

  // The RAM read for S2 was issued before the previous packet's write landed, so take that value directly.
  assign rmw_base = (s3_valid && s3_bin == s2_bin) ? s3_val : ram_rdata;
  assign rmw_val  = BIN_WIDTH'(sat_inc(64'(rmw_base), BIN_WIDTH));

  assign ram_we    = busy || (s2_valid && !clear);
  assign ram_waddr = busy ? clr_addr : s2_bin;
  assign ram_wdata = busy ? '0 : rmw_val;

  hist_ram #(
    .DEPTH (NUM_BINS),
    .WIDTH (BIN_WIDTH)
  ) u_bins (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (s1_bin),
    .rdata_a (ram_rdata),
    .raddr_b (rd_addr),
    .rclr_b  (busy || clear || !rst_n),
    .rdata_b (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pkt_count <= '0;
      lat_sum   <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      error     <= 1'b0;
    end else begin
      if (s2_valid) begin
        pkt_count <= pkt_count + COUNT_WIDTH'(1);
        lat_sum   <= lat_sum + s2_lat;
        if (s2_lat < lat_min) lat_min <= s2_lat;
        if (s2_lat > lat_max) lat_max <= s2_lat;
      end
      if (accept && axis_in_tdest != TDEST_WIDTH'(TDEST)) error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_latency_histogram.sv
// Scoreboard bench for axis_latency_histogram with a second instance using 4-bit saturating bins.
`default_nettype none

module tb_axis_latency_histogram;

  localparam int TDW = 512;
  localparam int TSW = TDW / 2;
  localparam int NB  = 64;
  localparam int BS  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic [TDW-1:0]  tdata = '0;
  logic [1:0]      tid = '0;
  logic [1:0]      tdest = '0;
  logic [5:0]      rd_addr = '0;
  logic            rd_req = 1'b0;
  logic            rd_issued = 1'b0;
  logic [TSW-1:0]  tick_cnt = '0;
  logic [TSW-1:0]  tick_off = '0;
  logic [TSW-1:0]  ticks;

  logic            tready, busy, error;
  logic [31:0]     rd_data, pkt_count;
  logic [TSW-1:0]  lat_sum, lat_min, lat_max;
  logic            tready4, busy4, error4;
  logic [3:0]      rd_data4;
  logic [31:0]     pkt_count4;
  logic [TSW-1:0]  lat_sum4, lat_min4, lat_max4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]    cnt;
    logic [TSW-1:0] sum;
    logic [TSW-1:0] mn;
    logic [TSW-1:0] mx;
  } snap_t;
  typedef struct {
    int          addr;
    logic [31:0] e32;
    logic [3:0]  e4;
  } rd_t;

  snap_t stat_q[$];
  rd_t   rd_q[$];

  int unsigned    m_bins[NB];
  logic [31:0]    m_count;
  logic [TSW-1:0] m_sum, m_min, m_max;
  logic           m_err;

  assign ticks = tick_cnt + tick_off;
  always #5 clk = ~clk;
  always @(posedge clk) tick_cnt <= tick_cnt + 1'b1;
  always @(posedge clk) rd_issued <= rd_req;

  axis_latency_histogram dut (
    .clk(clk), .rst_n(rst_n), .ticks(ticks), .clear(clear), .busy(busy),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .rd_addr(rd_addr), .rd_data(rd_data), .pkt_count(pkt_count),
    .lat_sum(lat_sum), .lat_min(lat_min), .lat_max(lat_max), .error(error)
  );

  axis_latency_histogram #(.BIN_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ticks(ticks), .clear(clear), .busy(busy4),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready4), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .rd_addr(rd_addr), .rd_data(rd_data4), .pkt_count(pkt_count4),
    .lat_sum(lat_sum4), .lat_min(lat_min4), .lat_max(lat_max4), .error(error4)
  );

  task automatic chk(input string nm, input logic [TSW-1:0] act, input logic [TSW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [TSW-1:0] cur_ticks();
    return tick_cnt + tick_off;
  endfunction

  function automatic int exp_bin(input logic [TSW-1:0] lat);
    logic [TSW-1:0] q;
    q = lat / (TSW'(1) << BS);
    if (q > TSW'(NB - 1)) return NB - 1;
    return int'(q);
  endfunction

  task automatic m_reset();
    foreach (m_bins[i]) m_bins[i] = 0;
    m_count = '0;
    m_sum   = '0;
    m_min   = '1;
    m_max   = '0;
    m_err   = 1'b0;
  endtask

  task automatic send(input logic [TSW-1:0] lat, input logic last, input logic [1:0] dest);
    logic [TSW-1:0] ts, lat_e;
    snap_t s;
    ts = cur_ticks() - lat;
    for (int w = 0; w < TDW / 32; w++) tdata[w*32 +: 32] = $urandom;
    tdata[TSW-1:0] = ts;
    tvalid = 1'b1;
    tlast  = last;
    tdest  = dest;
    tid    = 2'($urandom);
    chk("tready_on_send", {{(TSW-1){1'b0}}, tready}, 1);
    if (dest != 2'd0) m_err = 1'b1;
    if (last) begin
      lat_e = cur_ticks() - ts;
      m_bins[exp_bin(lat_e)]++;
      m_count++;
      m_sum += lat_e;
      if (lat_e < m_min) m_min = lat_e;
      if (lat_e > m_max) m_max = lat_e;
      s.cnt = m_count; s.sum = m_sum; s.mn = m_min; s.mx = m_max;
      stat_q.push_back(s);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_read(input int a);
    rd_t r;
    rd_addr = 6'(a);
    rd_req  = 1'b1;
    r.addr = a;
    r.e32  = 32'(m_bins[a]);
    r.e4   = (m_bins[a] > 15) ? 4'd15 : 4'(m_bins[a]);
    rd_q.push_back(r);
  endtask

  task automatic read_bins(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      push_read(a);
      @(negedge clk);
    end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    snap_t s;
    clear  = 1'b1;
    tvalid = 1'b1;
    tlast  = 1'b1;
    tdest  = 2'd0;
    tdata[TSW-1:0] = cur_ticks() - 5;
    if (m_count != 0) begin
      s.cnt = '0; s.sum = '0; s.mn = '1; s.mx = '0;
      stat_q.push_back(s);
    end
    m_reset();
    @(negedge clk);
    clear  = 1'b0;
    tvalid = 1'b0;
  endtask

  // Monitor: compares host reads one cycle after issue and statistics whenever pkt_count moves.
  rd_t         mon_r;
  snap_t       mon_s;
  logic [31:0] last_cnt = '0;
  always @(negedge clk) begin
    if (rd_issued) begin
      if (rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else begin
        mon_r = rd_q.pop_front();
        chk($sformatf("bin%0d", mon_r.addr), TSW'(rd_data), TSW'(mon_r.e32));
        chk($sformatf("bin4_%0d", mon_r.addr), TSW'(rd_data4), TSW'(mon_r.e4));
      end
    end
    if (rst_n && pkt_count !== last_cnt) begin
      if (stat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stat_unexpected: got pkt_count %0d expected no change", pkt_count);
      end else begin
        mon_s = stat_q.pop_front();
        chk("pkt_count", TSW'(pkt_count), TSW'(mon_s.cnt));
        chk("lat_sum", lat_sum, mon_s.sum);
        chk("lat_min", lat_min, mon_s.mn);
        chk("lat_max", lat_max, mon_s.mx);
      end
    end
    last_cnt = pkt_count;
  end

  initial begin
    int n;
    m_reset();
    tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready", TSW'(tready), 0);
    chk("rst_busy", TSW'(busy), 1);
    chk("rst_pkt_count", TSW'(pkt_count), 0);
    chk("rst_lat_sum", lat_sum, 0);
    chk("rst_lat_min", lat_min, '1);
    chk("rst_lat_max", lat_max, 0);
    chk("rst_rd_data", TSW'(rd_data), 0);
    chk("rst_error", TSW'(error), 0);

    rst_n = 1'b1;
    n = 0;
    while (!tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("reset_sweep_cycles", TSW'(n), 64);
    idle(1);
    read_bins(0, NB - 1);

    send(10, 1'b1, 2'd0);
    idle(4);
    read_bins(2, 2);

    repeat (100) send(7, 1'b1, 2'd0);
    idle(4);
    read_bins(1, 1);

    send(1000, 1'b1, 2'd0);
    idle(1);
    tick_off = TSW'(16) - tick_cnt;
    send(TSW'(32), 1'b1, 2'd0);
    idle(4);
    read_bins(63, 63);
    read_bins(8, 8);

    for (int w = 0; w < TSW / 32; w++) tick_off[w*32 +: 32] = $urandom;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 2) idle(1);
      else if ($urandom_range(0, 9) == 0) send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 2'd0);
      else send(TSW'($urandom_range(0, 300)), ($urandom_range(0, 3) != 0), 2'd0);
    end
    idle(4);
    read_bins(0, NB - 1);

    send(3, 1'b0, 2'd3);
    idle(2);
    chk("error_set", TSW'(error), TSW'(m_err));
    idle(10);
    chk("error_sticky", TSW'(error), 1);

    do_clear();
    n = 0;
    while (busy && n < 200) begin
      n++;
      push_read((NB - n) & (NB - 1));
      @(negedge clk);
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("clear_sweep_cycles", TSW'(n), 64);
    chk("error_cleared", TSW'(error), TSW'(m_err));

    repeat (20) send(12, 1'b1, 2'd0);
    idle(4);
    read_bins(0, NB - 1);

    idle(4);
    chk("stat_queue_drained", TSW'(stat_q.size()), 0);
    chk("rd_queue_drained", TSW'(rd_q.size()), 0);
    chk("final_lat_sum", lat_sum, m_sum);
    chk("final_pkt_count", TSW'(pkt_count), TSW'(m_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
